// File: rtl/qspi_line_fetch_pkg.sv
// Shared constants for the QSPI line fetcher: flash opcode, frame lengths and FSM encoding.
package qspi_line_fetch_pkg;

   localparam logic [7:0] QSPI_CMD_QREAD = 8'h6B;
   localparam int         SPI_CMD_LEN    = 8;
   localparam int         SPI_ADDR_LEN   = 24;
   localparam int         SPI_HDR_LEN    = SPI_CMD_LEN + SPI_ADDR_LEN;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CMD   = 3'd1,
      ST_ADDR  = 3'd2,
      ST_DUMMY = 3'd3,
      ST_DATA  = 3'd4,
      ST_END   = 3'd5
   } fetch_state_t;

endpackage

// File: rtl/qspi_nibble_buffer.sv
// Line buffer of NIBBLES 4-bit entries: one write port, asynchronous read with out-of-range reads as zero.
module qspi_nibble_buffer #(
   parameter int NIBBLES = 136,
   parameter int IDX_W   = $clog2(NIBBLES)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [IDX_W-1:0] widx,
   input  logic [3:0]       wdata,
   input  logic [IDX_W-1:0] rd_idx,
   output logic [3:0]       rd_data
);

   logic [NIBBLES-1:0][3:0] mem;

   // Deliberately unreset: a partial line must survive a reset.
   genvar gi;
   generate
      for (gi = 0; gi < NIBBLES; gi++) begin : g_entry
         logic [3:0] entry_reg;
         always_ff @(posedge clk) begin
            if (we && (widx == IDX_W'(gi))) begin
               entry_reg <= wdata;
            end
         end
         assign mem[gi] = entry_reg;
      end
   endgenerate

   assign rd_data = (32'(rd_idx) < NIBBLES) ? mem[rd_idx] : 4'h0;

endmodule

// File: rtl/qspi_line_fetch.sv
// Quad Output Fast Read (6Bh) fetcher: streams one line of nibbles from QSPI flash into a local buffer.
module qspi_line_fetch
   import qspi_line_fetch_pkg::*;
#(
   parameter int NIBBLES    = 136,
   parameter int DUMMY_CLKS = 8,
   parameter int IDX_W      = $clog2(NIBBLES)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [23:0]      addr,
   output logic             busy,
   output logic             done,
   output logic             spi_cs,
   output logic             spi_sclk,
   input  logic [3:0]       spi_in,
   output logic             spi_out0,
   output logic             spi_dir0,
   input  logic [IDX_W-1:0] rd_idx,
   output logic [3:0]       rd_data
);

   localparam int K_DATA = SPI_HDR_LEN + DUMMY_CLKS;
   localparam int K_END  = K_DATA + NIBBLES;
   localparam int K_W    = $clog2(K_END + 1);

   fetch_state_t            state_reg, state_next;
   logic [K_W-1:0]          k_reg, k_next, k_inc;
   logic [SPI_ADDR_LEN-1:0] addr_reg, addr_next;
   logic [3:0]              cap_reg;
   logic [2:0]              cmd_bit;
   logic [4:0]              addr_bit;
   logic                    buf_we;
   logic [IDX_W-1:0]        buf_widx;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg <= ST_IDLE;
         k_reg     <= '0;
         addr_reg  <= '0;
      end else begin
         state_reg <= state_next;
         k_reg     <= k_next;
         addr_reg  <= addr_next;
      end
   end

   assign k_inc = k_reg + K_W'(1);

   // Phase is derived from the cycle count that the next edge will produce.
   always_comb begin
      state_next = state_reg;
      k_next     = k_reg;
      addr_next  = addr_reg;
      case (state_reg)
         ST_IDLE: begin
            if (start) begin
               state_next = ST_CMD;
               k_next     = '0;
               addr_next  = addr;
            end
         end
         ST_END: begin
            state_next = ST_IDLE;
            k_next     = '0;
         end
         default: begin
            k_next = k_inc;
            if (k_inc < K_W'(SPI_CMD_LEN))      state_next = ST_CMD;
            else if (k_inc < K_W'(SPI_HDR_LEN)) state_next = ST_ADDR;
            else if (k_inc < K_W'(K_DATA))      state_next = ST_DUMMY;
            else if (k_inc < K_W'(K_END))       state_next = ST_DATA;
            else                                state_next = ST_END;
         end
      endcase
   end

   assign cmd_bit  = 3'(SPI_CMD_LEN - 1) - k_reg[2:0];
   assign addr_bit = 5'(SPI_HDR_LEN - 1) - k_reg[4:0];

   always_comb begin
      spi_out0 = 1'b0;
      case (state_reg)
         ST_CMD:  spi_out0 = QSPI_CMD_QREAD[cmd_bit];
         ST_ADDR: spi_out0 = addr_reg[addr_bit];
         default: spi_out0 = 1'b0;
      endcase
   end

   assign spi_cs   = (state_reg == ST_CMD) || (state_reg == ST_ADDR) ||
                     (state_reg == ST_DUMMY) || (state_reg == ST_DATA);
   assign spi_dir0 = (state_reg == ST_DUMMY) || (state_reg == ST_DATA) || (state_reg == ST_END);
   assign busy     = (state_reg != ST_IDLE);
   assign done     = (state_reg == ST_END);
   assign spi_sclk = spi_cs & ~clk;

   // Sampled on rising SCLK, i.e. half a cycle after the flash launched the nibble.
   always_ff @(negedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cap_reg <= '0;
      end else if (state_reg == ST_DATA) begin
         cap_reg <= spi_in;
      end
   end

   assign buf_we   = (state_reg == ST_DATA);
   assign buf_widx = IDX_W'(k_reg - K_W'(K_DATA));

   qspi_nibble_buffer #(
      .NIBBLES (NIBBLES),
      .IDX_W   (IDX_W)
   ) u_buffer (
      .clk     (clk),
      .we      (buf_we),
      .widx    (buf_widx),
      .wdata   (cap_reg),
      .rd_idx  (rd_idx),
      .rd_data (rd_data)
   );

endmodule

// File: tb/tb_qspi_line_fetch.sv
// Randomised bench for qspi_line_fetch: timeline model, flash model and per-cycle output compare.
`timescale 1ns/1ps
module tb_qspi_line_fetch;

   localparam int N      = 136;
   localparam int IW     = $clog2(N);
   localparam int K_DONE = 40 + N;

   logic          clk     = 1'b0;
   logic          reset_n = 1'b0;
   logic          start   = 1'b0;
   logic [23:0]   addr    = '0;
   logic [3:0]    spi_in  = '0;
   logic [IW-1:0] rd_idx  = '0;
   logic          busy, done, spi_cs, spi_sclk, spi_out0, spi_dir0;
   logic [3:0]    rd_data;

   int n_total = 0;
   int n_pass  = 0;
   int cyc     = 0;
   bit rand_rd = 1'b0;

   always #5 clk = ~clk;

   qspi_line_fetch #(
      .NIBBLES    (N),
      .DUMMY_CLKS (8)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .start    (start),
      .addr     (addr),
      .busy     (busy),
      .done     (done),
      .spi_cs   (spi_cs),
      .spi_sclk (spi_sclk),
      .spi_in   (spi_in),
      .spi_out0 (spi_out0),
      .spi_dir0 (spi_dir0),
      .rd_idx   (rd_idx),
      .rd_data  (rd_data)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Timeline model: a fetch occupies cycles k = 0 .. 40+N after acceptance.
   logic [3:0]  line_data [N];
   logic [3:0]  m_buf [N];
   bit          m_known [N];
   bit          m_active = 1'b0;
   int          m_k = 0;
   logic [23:0] m_addr = '0;
   int          e0 = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_active <= 1'b0;
         m_k      <= 0;
      end else if (!m_active) begin
         if (start) begin
            m_active <= 1'b1;
            m_k      <= 0;
            m_addr   <= addr;
            e0       <= cyc + 1;
         end
      end else begin
         if (m_k >= 40 && m_k < K_DONE) begin
            m_buf[m_k-40]   <= line_data[m_k-40];
            m_known[m_k-40] <= 1'b1;
         end
         if (m_k == K_DONE) m_active <= 1'b0;
         else               m_k <= m_k + 1;
      end
   end

   // Flash model: shifts in MOSI on rising SCLK, launches data nibbles on falling SCLK.
   int          rise_cnt = 0;
   logic [31:0] mosi_sr  = '0;

   always @(posedge spi_sclk or negedge spi_cs) begin
      if (!spi_cs) begin
         rise_cnt <= 0;
      end else begin
         if (rise_cnt < 32) mosi_sr <= {mosi_sr[30:0], spi_out0};
         rise_cnt <= rise_cnt + 1;
      end
   end

   always @(negedge spi_sclk) begin
      if (rise_cnt >= 40 && rise_cnt < K_DONE) spi_in = line_data[rise_cnt-40];
      else                                     spi_in = 4'($urandom);
   end

   always @(negedge clk) begin
      if (rand_rd) rd_idx = IW'($urandom_range(0, 255));
   end

   // Per-cycle compare plus edge monitors used by the directed checks.
   logic        e_cs, e_dir, e_out0, prev_cs = 1'b0, prev_dir = 1'b0;
   logic [31:0] hdr_w;
   logic [31:0] mosi_word = '0;
   int cs_rise = -1, cs_rise_prev = -1, cs_run = 0, dir_rise = -1, done_cnt = 0, done_cyc = -1;

   always begin
      @(negedge clk);
      #1;
      hdr_w  = {8'h6B, m_addr};
      e_cs   = m_active && (m_k < K_DONE);
      e_dir  = m_active && (m_k >= 32);
      e_out0 = (m_active && m_k < 32) ? hdr_w[31-m_k] : 1'b0;
      check("cs",   32'(spi_cs),   32'(e_cs));
      check("sclk", 32'(spi_sclk), 32'(e_cs));
      check("busy", 32'(busy),     32'(m_active));
      check("done", 32'(done),     32'(m_active && m_k == K_DONE));
      check("dir0", 32'(spi_dir0), 32'(e_dir));
      check("out0", 32'(spi_out0), 32'(e_out0));
      if (32'(rd_idx) >= N)       check("rd_oor",  32'(rd_data), 32'd0);
      else if (m_known[rd_idx])   check("rd_data", 32'(rd_data), 32'(m_buf[rd_idx]));
      if (m_active && m_k == 32) begin
         mosi_word = mosi_sr;
         check("mosi_hdr", mosi_sr, hdr_w);
      end
      if (spi_cs && !prev_cs) begin
         cs_rise_prev = cs_rise;
         cs_rise      = cyc;
         cs_run       = 0;
      end
      if (spi_cs) cs_run++;
      if (spi_dir0 && !prev_dir) dir_rise = cyc;
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
         $display("fetch addr=%06h done at cycle %0d", m_addr, cyc);
      end
      prev_cs  = spi_cs;
      prev_dir = spi_dir0;
   end

   task automatic start_fetch(input logic [23:0] a);
      @(negedge clk);
      addr  = a;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      addr  = 24'($urandom);
   endtask

   task automatic wait_done(input int budget);
      int c0 = done_cnt;
      int i  = 0;
      while (done_cnt == c0 && i < budget) begin
         @(negedge clk);
         i++;
      end
      check("done_timeout", 32'(done_cnt != c0), 32'd1);
   endtask

   task automatic wait_k(input int target, input int budget);
      int i = 0;
      while (!(m_active && m_k == target) && i < budget) begin
         @(negedge clk);
         i++;
      end
      check("k_timeout", 32'(m_active && m_k == target), 32'd1);
   endtask

   task automatic fill_random();
      for (int i = 0; i < N; i++) line_data[i] = 4'($urandom);
   endtask

   initial begin
      int          c0;
      logic [3:0]  b_hi;
      logic [23:0] a;

      // Reset state
      repeat (3) @(negedge clk);
      #1;
      check("rst_busy", 32'(busy),     32'd0);
      check("rst_cs",   32'(spi_cs),   32'd0);
      check("rst_sclk", 32'(spi_sclk), 32'd0);
      check("rst_dir0", 32'(spi_dir0), 32'd0);
      check("rst_out0", 32'(spi_out0), 32'd0);
      check("rst_done", 32'(done),     32'd0);
      @(negedge clk);
      reset_n = 1'b1;

      // Basic fetch with a 0..F repeating nibble stream
      for (int i = 0; i < N; i++) line_data[i] = 4'(i % 16);
      rand_rd = 1'b1;
      c0 = done_cnt;
      start_fetch(24'h000A40);
      wait_done(300);
      repeat (4) @(negedge clk);
      check("basic_mosi",     mosi_word, 32'h6B000A40);
      check("basic_cs_rise",  32'(cs_rise - e0),  32'd0);
      check("basic_dir_k",    32'(dir_rise - cs_rise), 32'd32);
      check("basic_cs_len",   32'(cs_run),        32'd176);
      check("basic_done_at",  32'(done_cyc - e0), 32'd176);
      check("basic_done_cnt", 32'(done_cnt - c0), 32'd1);

      // Full-range readback, including the out-of-range indices
      rand_rd = 1'b0;
      for (int i = 0; i < 256; i++) begin
         @(negedge clk);
         rd_idx = IW'(i);
         #1;
         check("sweep", 32'(rd_data), (i < N) ? 32'(i % 16) : 32'd0);
      end
      @(negedge clk);
      rd_idx = '0;
      #2;
      b_hi   = rd_data;
      rd_idx = IW'(1);
      #2;
      check("byte0", 32'({b_hi, rd_data}), 32'h01);

      // Starts during a fetch and in the END cycle are ignored
      fill_random();
      rand_rd = 1'b1;
      a  = 24'($urandom);
      c0 = done_cnt;
      start_fetch(a);
      wait_k(50, 100);
      addr  = 24'($urandom);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_k(K_DONE, 200);
      addr  = 24'($urandom);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      check("ign_busy",     32'(busy),          32'd0);
      check("ign_done_cnt", 32'(done_cnt - c0), 32'd1);
      check("ign_mosi",     mosi_word,          {8'h6B, a});

      // Back-to-back with start held high
      fill_random();
      @(negedge clk);
      addr  = 24'($urandom);
      start = 1'b1;
      wait_done(300);
      for (int i = 0; i < 10 && cs_rise <= done_cyc; i++) @(negedge clk);
      check("b2b_gap",    32'(cs_rise - done_cyc),     32'd2);
      check("b2b_period", 32'(cs_rise - cs_rise_prev), 32'd178);
      start = 1'b0;
      wait_done(300);

      // Asynchronous reset in the middle of a fetch
      fill_random();
      start_fetch(24'($urandom));
      wait_k(60, 100);
      #3;
      reset_n = 1'b0;
      #1;
      check("arst_cs",   32'(spi_cs),   32'd0);
      check("arst_sclk", 32'(spi_sclk), 32'd0);
      check("arst_busy", 32'(busy),     32'd0);
      check("arst_dir0", 32'(spi_dir0), 32'd0);
      a     = 24'($urandom);
      addr  = a;
      start = 1'b1;
      @(negedge clk);
      @(negedge clk);
      #3;
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      check("arst_accept_busy", 32'(busy),   32'd1);
      check("arst_accept_cs",   32'(spi_cs), 32'd1);
      @(negedge clk);
      start = 1'b0;
      wait_done(300);
      check("arst_mosi", mosi_word, {8'h6B, a});

      // Random fetches with random idle gaps
      for (int t = 0; t < 3; t++) begin
         fill_random();
         repeat ($urandom_range(0, 5)) @(negedge clk);
         a = 24'($urandom);
         start_fetch(a);
         wait_done(300);
         check("rand_mosi", mosi_word, {8'h6B, a});
      end
      repeat (3) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
